// File: rtl/apb_master_port.sv
// rtl/apb_master_port.sv - APB4 requester turning single-beat commands into APB transfers
// Optional ACCESS watchdog compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_port #(
  parameter int APB_ADDRWIDTH  = 16,
  parameter int APB_DATAWIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     pclk_i,
  input  logic                     prst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [APB_ADDRWIDTH-1:0] cmd_addr_i,
  input  logic [APB_DATAWIDTH-1:0] cmd_wdata_i,
  input  logic [3:0]               cmd_strb_i,
  output logic                     rsp_valid_o,
  output logic [APB_DATAWIDTH-1:0] rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [APB_ADDRWIDTH-1:0] paddr_o,
  output logic                     psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [APB_DATAWIDTH-1:0] pwdata_o,
  output logic [3:0]               pstrb_o,
  input  logic                     pready_i,
  input  logic [APB_DATAWIDTH-1:0] prdata_i,
  input  logic                     pslverr_i
);

  localparam int         STRB_W    = APB_DATAWIDTH / 8;
  localparam logic [3:0] STRB_MASK = 4'((1 << STRB_W) - 1);

  if (TIMEOUT_CYCLES < 1 ||
      !(APB_DATAWIDTH == 8 || APB_DATAWIDTH == 16 || APB_DATAWIDTH == 32)) begin : g_param_check
    $error("apb_master_port: illegal APB_DATAWIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign cmd_ready_o = (state == IDLE) && !prst_i;

  // The APB outputs double as the command register: loaded on accept, zeroed on return to IDLE.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state       <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= 4'h0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state     <= SETUP;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            pwrite_o  <= cmd_write_i;
            paddr_o   <= cmd_addr_i;
            pwdata_o  <= cmd_write_i ? cmd_wdata_i : '0;
            pstrb_o   <= cmd_write_i ? (cmd_strb_i & STRB_MASK) : 4'h0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= pslverr_i;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= 4'h0;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // This cycle is the TIMEOUT_CYCLES-th unanswered ACCESS cycle: abort with error.
          else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= 4'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_port.md
# apb_master_port

APB4 requester that turns single-beat commands from the memory-controller config sequencer into APB transfers toward `apb_slave_port` and other APB register blocks on the LPDDR3/4 MC config bus. It runs the SETUP/ACCESS handshake, holds on wait states, and returns read data and error status on a one-cycle response strobe. An optional watchdog aborts transfers whose slave never asserts `pready_i`.

## Interface
- `APB_ADDRWIDTH`, 16: width of `paddr_o` and `cmd_addr_i`.
- `APB_DATAWIDTH`, 32: data width; legal values 8, 16, 32.
- `TIMEOUT_CYCLES`, 16: ACCESS wait-state limit when the watchdog is compiled in; must be ≥1.
- Clock and reset: one clock; reset is synchronous and active-high.
- `pclk_i`  in  1  clock; all logic on rising edge.
- `prst_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  APB_ADDRWIDTH  byte address.
- `cmd_wdata_i`  in  APB_DATAWIDTH  write data.
- `cmd_strb_i`  in  4  byte strobes; only the low APB_DATAWIDTH/8 bits are used.
- `rsp_valid_o`  out  1  one-cycle completion strobe.
- `rsp_rdata_o`  out  APB_DATAWIDTH  read data; 0 for writes.
- `rsp_err_o`  out  1  `pslverr_i` or timeout.
- `paddr_o`  out  APB_ADDRWIDTH  APB address.
- `psel_o`  out  1  APB select.
- `penable_o`  out  1  APB enable.
- `pwrite_o`  out  1  APB direction.
- `pwdata_o`  out  APB_DATAWIDTH  APB write data.
- `pstrb_o`  out  4  APB strobes.
- `pready_i`  in  1  slave ready.
- `prdata_i`  in  APB_DATAWIDTH  slave read data.
- `pslverr_i`  in  1  slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready_o` = 1, except while `prst_i` = 1, when it is 0.
  - On `cmd_valid_i` & `cmd_ready_o`, register write, addr, wdata and strb, then go to SETUP.
- SETUP:
  - `psel_o` = 1, `penable_o` = 0.
  - Address, direction, data and strobes driven from the registered command.
  - Unconditionally go to ACCESS.
- ACCESS:
  - `psel_o` = 1, `penable_o` = 1; all APB outputs held stable.
  - On `pready_i` = 1: capture `prdata_i` (reads only) and `pslverr_i`, then go to IDLE.
  - On `pready_i` = 0: stay in ACCESS.
- Reads drive `pstrb_o` = 0 and `pwdata_o` = 0. Writes drive the registered strobes, masked to APB_DATAWIDTH/8 bits.
- Outside SETUP/ACCESS, all APB outputs are 0.
- Reset mid-transfer: next edge forces IDLE and drops `psel_o`/`penable_o`. No `rsp_valid_o` is issued for the aborted command.
- Reset values: `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `pstrb_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o` all 0; state IDLE.

## Timing
- Cycle N: command accepted. N+1: SETUP. N+2: first ACCESS cycle.
- Zero wait states: `pready_i` high at N+2, `rsp_valid_o` high at N+3, which is also an IDLE cycle with `cmd_ready_o` = 1.
- Throughput: one transfer per 3 cycles minimum.
- Each `pready_i` = 0 cycle in ACCESS adds exactly one cycle of latency.
- `rsp_valid_o` is high for exactly one cycle. `rsp_rdata_o` and `rsp_err_o` are valid only in that cycle and return to 0 afterwards.
- `cmd_*` inputs are ignored outside IDLE; there is no queueing.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles with `pready_i` = 0; it clears on entry to SETUP.
  - When the count reaches TIMEOUT_CYCLES with `pready_i` still 0, next edge goes to IDLE with `psel_o`/`penable_o` = 0, and issues `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_rdata_o` = 0.
  - If `pready_i` = 1 in the limit cycle, normal completion wins.
- `APB_MASTER_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely for `pready_i`.

## Test plan
- Write `addr` = 0x0000, `wdata` = 0x0000005A, `strb` = 4'b0001, `pready_i` tied 1 -> `psel_o` rises at N+1 and `penable_o` at N+2; `pwdata_o` = 0x5A, `pstrb_o` = 0001; `rsp_valid_o` at N+3 with `rsp_err_o` = 0, `rsp_rdata_o` = 0.
- Read `addr` = 0x0000 with `prdata_i` = 0x0000005A -> `pstrb_o` = 0 and `pwdata_o` = 0 during the transfer; `rsp_rdata_o` = 0x0000005A at N+3.
- Read with `pready_i` low for 3 ACCESS cycles -> `penable_o` high for 4 cycles with `paddr_o` stable; `rsp_valid_o` at N+6.
- Write with `pslverr_i` = 1 in the ready cycle -> `rsp_err_o` = 1 for one cycle; next command accepted in that same cycle.
- With `APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, `pready_i` held 0 -> abort after 4 ACCESS cycles; `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_rdata_o` = 0. Without the macro -> FSM still in ACCESS after 100 cycles.
- `prst_i` pulsed during ACCESS -> `psel_o` = 0 next cycle, no `rsp_valid_o`; `cmd_ready_o` = 1 the cycle after `prst_i` falls.
